// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus a small memory-mapped I/O page (UART RX/TX, cycle
// counter, stop request) answering a single-port CPU bus. Reads are
// registered; the TX path is a byte FIFO with sticky overflow.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH       = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int unsigned PTR_W     = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WIDTH;

    logic [7:0]                ram_q  [RAM_BYTES];
    logic [7:0]                fifo_q [TX_DEPTH];

    logic [7:0]                cpu_din_q;
    logic                      rx_ready_q;
    logic [31:0]               counter_q;
    logic [31:0]               snap_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          count_d;
    logic                      tx_valid_q;
    logic                      io_full_q;
    logic                      overflow_q;
    logic                      stop_pend_q;
    logic                      prog_stop_q;

    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]               io_off;
    logic                      io_sel;
    logic                      ram_we;
    logic                      uart_rd;
    logic                      uart_wr;
    logic                      ctr_rd;
    logic                      stop_wr;
    logic                      push;
    logic                      pop;
    logic                      push_ok;
    logic [7:0]                push_data;
    logic [7:0]                rd_data_c;
    logic                      unused_addr_hi;

    // Address decode: the I/O page is selected by bits 17:16 == 2'b11
    assign ram_addr       = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign io_off         = cpu_a[15:0];
    assign io_sel         = (cpu_a[17:16] == 2'b11);
    assign ram_we         = cpu_wr && !io_sel;
    assign uart_rd        = !cpu_wr && io_sel && (io_off == 16'h0000);
    assign uart_wr        = cpu_wr && io_sel && (io_off == 16'h0000) && (cpu_dout != 8'h00);
    assign ctr_rd         = !cpu_wr && io_sel && (io_off == 16'h0004);
    assign stop_wr        = cpu_wr && io_sel && (io_off == 16'h0004);
    assign unused_addr_hi = ^cpu_a[31:18];

    // TX FIFO handshake: a full FIFO still accepts when it pops in the same cycle
    assign push      = uart_wr || stop_wr;
    assign push_data = stop_wr ? 8'h00 : cpu_dout;
    assign pop       = tx_valid_q && tx_ready;
    assign push_ok   = push && ((count_q < CNT_W'(TX_DEPTH)) || pop);
    assign count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Read data selection for the registered read port
    always_comb begin
        rd_data_c = ram_q[ram_addr];
        if (io_sel) begin
            case (io_off)
                16'h0000: rd_data_c = rx_valid ? rx_data : 8'h00;
                16'h0004: rd_data_c = counter_q[7:0];
                16'h0005: rd_data_c = snap_q[15:8];
                16'h0006: rd_data_c = snap_q[23:16];
                16'h0007: rd_data_c = snap_q[31:24];
                default:  rd_data_c = 8'h00;
            endcase
        end
    end

    // Control and status registers; reset overrides any access in the same cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_din_q   <= 8'h00;
            rx_ready_q  <= 1'b0;
            counter_q   <= 32'd0;
            snap_q      <= 32'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_valid_q  <= 1'b0;
            io_full_q   <= 1'b0;
            overflow_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            prog_stop_q <= 1'b0;
        end else begin
            counter_q  <= counter_q + 32'd1;
            rx_ready_q <= uart_rd && rx_valid;
            if (!cpu_wr) begin
                cpu_din_q <= rd_data_c;
            end
            if (ctr_rd) begin
                snap_q <= counter_q;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            tx_valid_q <= (count_d != '0);
            io_full_q  <= (count_d >= CNT_W'(TX_DEPTH - 1));
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (stop_wr) begin
                stop_pend_q <= 1'b1;
            end
            if (stop_pend_q && (count_q == '0)) begin
                prog_stop_q <= 1'b1;
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (!rst_in && ram_we) begin
            ram_q[ram_addr] <= cpu_dout;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_in) begin
        if (!rst_in && push_ok) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign cpu_din        = cpu_din_q;
    assign rx_ready       = rx_ready_q;
    assign tx_valid       = tx_valid_q;
    assign tx_data        = fifo_q[rd_ptr_q];
    assign io_buffer_full = io_full_q;
    assign tx_overflow    = overflow_q;
    assign program_stop   = prog_stop_q;

endmodule
